// File: rtl/crossbar_2x2_sched_if.sv
// Handshake and crossbar-drive bundle between the two source ports, the scheduler and the crossbar.
interface crossbar_2x2_sched_if #(
    parameter int CW = 8
);
    logic          a_valid;
    logic [3:0]    a_data;
    logic          a_dest;
    logic          a_ready;
    logic          b_valid;
    logic [3:0]    b_data;
    logic          b_dest;
    logic          b_ready;
    logic [3:0]    xb_in1;
    logic [3:0]    xb_in2;
    logic          xb_control;
    logic          vld_out1;
    logic          vld_out2;
    logic [CW-1:0] conflict_cnt;

    modport slave (
        input  a_valid, a_data, a_dest, b_valid, b_data, b_dest,
        output a_ready, b_ready, xb_in1, xb_in2, xb_control,
               vld_out1, vld_out2, conflict_cnt
    );

    modport master (
        output a_valid, a_data, a_dest, b_valid, b_data, b_dest,
        input  a_ready, b_ready, xb_in1, xb_in2, xb_control,
               vld_out1, vld_out2, conflict_cnt
    );
endinterface

// File: rtl/crossbar_2x2_sched.sv
// Two-port input scheduler feeding a 2x2 crossbar: per-port 2-entry FIFOs,
// registered dispatch, round-robin on output conflicts, saturating conflict counter.
module crossbar_2x2_sched #(
    parameter int DEPTH = 2,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    crossbar_2x2_sched_if.slave  bus
);
    logic [4:0]    a_mem_q [2];
    logic [4:0]    b_mem_q [2];
    logic          a_rd_q, a_wr_q, b_rd_q, b_wr_q;
    logic [1:0]    a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    in1_q, in1_d, in2_q, in2_d;
    logic          ctrl_q, ctrl_d;
    logic          vld1_q, vld1_d, vld2_q, vld2_d;

    logic          a_ready, b_ready, push_a, push_b, pop_a, pop_b;
    logic          ha_v, hb_v, conflict;
    logic [4:0]    ha, hb;

    // Ready looks only at the registered count, so a full FIFO refuses a push even while popping.
    assign a_ready = (a_cnt_q < 2'(DEPTH));
    assign b_ready = (b_cnt_q < 2'(DEPTH));
    assign push_a  = bus.a_valid & a_ready;
    assign push_b  = bus.b_valid & b_ready;

    assign ha_v = (a_cnt_q != 2'd0);
    assign hb_v = (b_cnt_q != 2'd0);
    assign ha   = a_mem_q[a_rd_q];
    assign hb   = b_mem_q[b_rd_q];

    always_comb begin
        pop_a    = 1'b0;
        pop_b    = 1'b0;
        conflict = 1'b0;
        if (ha_v && hb_v) begin
            if (ha[4] != hb[4]) begin
                pop_a = 1'b1;
                pop_b = 1'b1;
            end else begin
                conflict = 1'b1;
                pop_a    = ~rr_q;
                pop_b    = rr_q;
            end
        end else begin
            pop_a = ha_v;
            pop_b = hb_v;
        end
    end

    always_comb begin
        in1_d  = pop_a ? ha[3:0] : 4'd0;
        in2_d  = pop_b ? hb[3:0] : 4'd0;
        ctrl_d = 1'b1;
        if (pop_a)
            ctrl_d = ~ha[4];
        else if (pop_b)
            ctrl_d = hb[4];
        vld1_d = (pop_a && !ha[4]) || (pop_b && !hb[4]);
        vld2_d = (pop_a && ha[4]) || (pop_b && hb[4]);

        a_cnt_d = a_cnt_q + {1'b0, push_a} - {1'b0, pop_a};
        b_cnt_d = b_cnt_q + {1'b0, push_b} - {1'b0, pop_b};

        rr_d  = conflict ? ~rr_q : rr_q;
        cnt_d = cnt_q;
        if (conflict && (cnt_q != {CW{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mem_q[0] <= 5'd0;
            a_mem_q[1] <= 5'd0;
            b_mem_q[0] <= 5'd0;
            b_mem_q[1] <= 5'd0;
            a_rd_q     <= 1'b0;
            a_wr_q     <= 1'b0;
            b_rd_q     <= 1'b0;
            b_wr_q     <= 1'b0;
            a_cnt_q    <= 2'd0;
            b_cnt_q    <= 2'd0;
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            in1_q      <= 4'd0;
            in2_q      <= 4'd0;
            ctrl_q     <= 1'b1;
            vld1_q     <= 1'b0;
            vld2_q     <= 1'b0;
        end else begin
            if (push_a) begin
                a_mem_q[a_wr_q] <= {bus.a_dest, bus.a_data};
                a_wr_q          <= ~a_wr_q;
            end
            if (push_b) begin
                b_mem_q[b_wr_q] <= {bus.b_dest, bus.b_data};
                b_wr_q          <= ~b_wr_q;
            end
            if (pop_a)
                a_rd_q <= ~a_rd_q;
            if (pop_b)
                b_rd_q <= ~b_rd_q;
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            ctrl_q  <= ctrl_d;
            vld1_q  <= vld1_d;
            vld2_q  <= vld2_d;
        end
    end

    assign bus.a_ready      = a_ready;
    assign bus.b_ready      = b_ready;
    assign bus.xb_in1       = in1_q;
    assign bus.xb_in2       = in2_q;
    assign bus.xb_control   = ctrl_q;
    assign bus.vld_out1     = vld1_q;
    assign bus.vld_out2     = vld2_q;
    assign bus.conflict_cnt = cnt_q;
endmodule
